// File: rtl/casc_ram_array.sv
// casc_ram_array: cleared-on-reset RAM array, NV banks x NH chips wide.
// Ports: CLK/RSTN, EN/WE/A/D/LANE request; Q/QV read-back; BUSY during clear.

// casc_ram_chip: one small RAM chip, synchronous write, asynchronous read.
// Ports: CLK, we, addr, d (write data), q (data at addr).
module casc_ram_chip #(
   parameter int W  = 4,
   parameter int AW = 2
) (
   input  logic          CLK,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [W-1:0]  d,
   output logic [W-1:0]  q
);

   logic [W-1:0] mem [2**AW];

   always_ff @(posedge CLK) begin
      if (we) begin
         mem[addr] <= d;
      end
   end

   assign q = mem[addr];

endmodule

// casc_ram_array top: muxes the clear sequencer or the request onto the
// chips and registers the read / write-through word onto Q.
module casc_ram_array #(
   parameter  int CHIP_W     = 4,
   parameter  int CHIP_AW    = 2,
   parameter  int NH         = 2,
   parameter  int NV         = 2,
   parameter  bit WRITE_THRU = 1'b0,
   localparam int BW         = $clog2(NV),
   localparam int AW         = CHIP_AW + BW,
   localparam int DW         = CHIP_W * NH
) (
   input  logic          CLK,
   input  logic          RSTN,
   input  logic          EN,
   input  logic          WE,
   input  logic [AW-1:0] A,
   input  logic [DW-1:0] D,
   input  logic [NH-1:0] LANE,
   output logic [DW-1:0] Q,
   output logic          QV,
   output logic          BUSY
);

   localparam int BSW = (BW > 0) ? BW : 1;

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   state_t state;

   logic [AW-1:0] clr_cnt;
   logic [AW-1:0] acc_addr;
   logic [BSW-1:0] bank;
   logic [CHIP_AW-1:0] row;

   logic [NH-1:0] chip_we [NV];
   logic [CHIP_W-1:0] chip_d [NH];
   logic [CHIP_W-1:0] chip_q [NV][NH];

   logic [DW-1:0] rd_word;
   logic [DW-1:0] merged;

   logic in_init;
   logic wr_req;

   assign in_init = (state == INIT);
   assign wr_req  = !in_init && EN && WE;

   // The sequencer owns the address bus while clearing.
   assign acc_addr = in_init ? clr_cnt : A;
   assign row      = acc_addr[CHIP_AW-1:0];

   if (BW > 0) begin : g_bank_sel
      assign bank = acc_addr[AW-1:CHIP_AW];
   end else begin : g_one_bank
      assign bank = '0;
   end

   // Chip enables: clear hits every lane of the addressed word; a request
   // hits only masked lanes of the selected bank. Nothing is written while
   // RSTN is low so reset leaves contents intact.
   always_comb begin
      for (int b = 0; b < NV; b++) begin
         chip_we[b] = '0;
         if (RSTN && bank == BSW'(b)) begin
            if (in_init) begin
               chip_we[b] = '1;
            end else if (wr_req) begin
               chip_we[b] = LANE;
            end
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NH; k++) begin
         chip_d[k] = in_init ? '0 : D[k*CHIP_W +: CHIP_W];
      end
   end

   // Old word of the selected bank, and the word as it reads after a write.
   always_comb begin
      rd_word = '0;
      merged  = '0;
      for (int k = 0; k < NH; k++) begin
         rd_word[k*CHIP_W +: CHIP_W] = chip_q[bank][k];
         merged[k*CHIP_W +: CHIP_W] = LANE[k] ?
            D[k*CHIP_W +: CHIP_W] : chip_q[bank][k];
      end
   end

   for (genvar b = 0; b < NV; b++) begin : g_bank
      for (genvar k = 0; k < NH; k++) begin : g_chip
         casc_ram_chip #(
            .W  (CHIP_W),
            .AW (CHIP_AW)
         ) u_chip (
            .CLK  (CLK),
            .we   (chip_we[b][k]),
            .addr (row),
            .d    (chip_d[k]),
            .q    (chip_q[b][k])
         );
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state   <= INIT;
         clr_cnt <= '0;
         Q       <= '0;
         QV      <= 1'b0;
         BUSY    <= 1'b1;
      end else begin
         QV <= 1'b0;
         unique case (state)
            INIT: begin
               clr_cnt <= clr_cnt + 1'b1;
               // Bank count is a power of two, so the last word is all ones.
               if (clr_cnt == '1) begin
                  state   <= RUN;
                  BUSY    <= 1'b0;
                  clr_cnt <= '0;
               end
            end
            RUN: begin
               if (EN) begin
                  if (!WE) begin
                     Q  <= rd_word;
                     QV <= 1'b1;
                  end else if (WRITE_THRU) begin
                     Q  <= merged;
                     QV <= 1'b1;
                  end
               end
            end
            default: begin
               state <= INIT;
            end
         endcase
      end
   end

endmodule
